// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter that drives the one-hot source selects of
// the shared 32-bit datapath bus (R0-R15, PC, MDR, InPort, HI, LO, ZHI, ZLO, C).
// A tenure counter forces a contended owner off the bus after MAX_HOLD cycles.
//
// Ports:
//   clk          system clock, rising edge
//   clr          asynchronous active-low reset
//   req          per-driver level request, held until granted
//   grant        registered one-hot bus-mux select
//   grant_valid  registered, high when any grant bit is set
//   grant_id     registered binary index of the owner, 0 when idle
//   preempt      registered one-cycle pulse after a forced switch-out
module bus_arbiter #(
    parameter int unsigned NUM_SRC  = 24,
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned ID_W     = 5
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NUM_SRC-1:0] req,
    output logic [NUM_SRC-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic               preempt
);

    localparam int unsigned TEN_W = $clog2(MAX_HOLD + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OWNED = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic               grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               preempt_q, preempt_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [TEN_W-1:0]   tenure_q, tenure_d;

    logic [NUM_SRC-1:0] own_mask_c;
    logic [NUM_SRC-1:0] others_c;
    logic               owner_req_c;
    logic [NUM_SRC-1:0] cand_c;
    logic               found_c;
    logic [ID_W-1:0]    win_c;

    // Requests other than the current owner's; in IDLE every request is a candidate.
    always_comb begin
        own_mask_c  = NUM_SRC'(1) << grant_id_q;
        others_c    = req & ~own_mask_c;
        owner_req_c = |(req & own_mask_c);
        cand_c      = (state_q == IDLE) ? req : others_c;
    end

    // Round-robin search: first candidate at or above rr_ptr, wrapping at NUM_SRC-1.
    always_comb begin
        int unsigned idx;
        idx     = 0;
        found_c = 1'b0;
        win_c   = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = (32'(rr_ptr_q) + k) % NUM_SRC;
            if (!found_c && cand_c[idx[ID_W-1:0]]) begin
                found_c = 1'b1;
                win_c   = idx[ID_W-1:0];
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        logic take;
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        preempt_d     = 1'b0;
        rr_ptr_d      = rr_ptr_q;
        tenure_d      = tenure_q;
        take          = 1'b0;

        case (state_q)
            IDLE: begin
                take = found_c;
            end
            OWNED: begin
                if (!owner_req_c) begin
                    // Release wins over tenure expiry, so no preempt here.
                    if (found_c) begin
                        take = 1'b1;
                    end else begin
                        state_d       = IDLE;
                        grant_d       = '0;
                        grant_valid_d = 1'b0;
                        grant_id_d    = '0;
                        tenure_d      = '0;
                    end
                end else if (others_c == '0) begin
                    if (tenure_q < TEN_W'(MAX_HOLD)) begin
                        tenure_d = tenure_q + TEN_W'(1);
                    end
                end else if (tenure_q < TEN_W'(MAX_HOLD)) begin
                    tenure_d = tenure_q + TEN_W'(1);
                end else begin
                    take      = 1'b1;
                    preempt_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take) begin
            state_d       = OWNED;
            grant_d       = NUM_SRC'(1) << win_c;
            grant_valid_d = 1'b1;
            grant_id_d    = win_c;
            tenure_d      = TEN_W'(1);
            rr_ptr_d      = (32'(win_c) == NUM_SRC - 1) ? '0 : ID_W'(32'(win_c) + 1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            preempt_q     <= 1'b0;
            rr_ptr_q      <= '0;
            tenure_q      <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            preempt_q     <= preempt_d;
            rr_ptr_q      <= rr_ptr_d;
            tenure_q      <= tenure_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed-vector bench for bus_arbiter with hand-computed
// expected grants, handovers, preemption and wrap-around behaviour.
module tb_bus_arbiter;

    localparam int unsigned NUM_SRC = 24;
    localparam int unsigned ID_W    = 5;

    logic               clk;
    logic               clr;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] grant;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic               preempt;

    int total;
    int bad;

    bus_arbiter #(
        .NUM_SRC (NUM_SRC),
        .MAX_HOLD(4),
        .ID_W    (ID_W)
    ) u_dut (
        .clk        (clk),
        .clr        (clr),
        .req        (req),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .preempt    (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; leaves time 1 ns after it for sampling and driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset mid-cycle with no requests; returns 3 ns after a rising edge.
    task automatic do_reset();
        step();
        req = '0;
        clr = 1'b0;
        #1;
        clr = 1'b1;
        #1;
    endtask

    task automatic check_owner(input string tag, input int id);
        check({tag, "_grant"}, 32'(grant), 32'(1) << id);
        check({tag, "_id"}, 32'(grant_id), 32'(id));
        check({tag, "_valid"}, 32'(grant_valid), 32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_id"}, 32'(grant_id), 32'd0);
        check({tag, "_valid"}, 32'(grant_valid), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        req   = '0;
        clr   = 1'b0;

        // 1. Reset
        #2;
        check_idle("rst_init");
        check("rst_init_pre", 32'(preempt), 32'd0);
        step();
        clr = 1'b1;
        req = NUM_SRC'(1) << 17;
        step();
        check_owner("rst_pre_own", 17);
        #2;
        clr = 1'b0;
        #1;
        check_idle("rst_async");
        check("rst_async_pre", 32'(preempt), 32'd0);
        clr = 1'b1;
        req = '0;
        step();
        check_idle("rst_after");
        req = NUM_SRC'(1) << 2;
        step();
        check_owner("rst_req2", 2);
        req = '0;
        step();
        check_idle("rst_rel2");

        // 2. Single request, long hold, then late contention after saturation
        do_reset();
        req = NUM_SRC'(1) << 17;
        step();
        check("single_grant_hex", 32'(grant), 32'h0002_0000);
        check_owner("single", 17);
        for (int i = 0; i < 10; i++) begin
            step();
            check("single_hold_grant", 32'(grant), 32'h0002_0000);
            check("single_hold_pre", 32'(preempt), 32'd0);
        end
        req = req | (NUM_SRC'(1) << 2);
        step();
        check_owner("sat_preempt", 2);
        check("sat_preempt_pulse", 32'(preempt), 32'd1);
        step();
        check("sat_preempt_clear", 32'(preempt), 32'd0);

        // 3. Simultaneous requests, handover without idle cycle
        do_reset();
        req = (NUM_SRC'(1) << 3) | (NUM_SRC'(1) << 20);
        step();
        check_owner("simul_first", 3);
        req = NUM_SRC'(1) << 20;
        #2;
        check_owner("simul_old_still", 3);
        step();
        check_owner("simul_handover", 20);
        check("simul_handover_pre", 32'(preempt), 32'd0);
        req = '0;
        step();
        check_idle("simul_idle");

        // 4. Preemption rotation between 5 and 6
        do_reset();
        req = (NUM_SRC'(1) << 5) | (NUM_SRC'(1) << 6);
        for (int c = 1; c <= 12; c++) begin
            step();
            check_owner("rot", (((c - 1) / 4) % 2 == 1) ? 6 : 5);
            check("rot_pre", 32'(preempt), (c > 1 && (c - 1) % 4 == 0) ? 32'd1 : 32'd0);
        end

        // 5. Wrap-around of the search pointer
        do_reset();
        req = NUM_SRC'(1) << 23;
        step();
        check_owner("wrap_own23", 23);
        req = (NUM_SRC'(1) << 0) | (NUM_SRC'(1) << 22);
        step();
        check_owner("wrap_to0", 0);
        do_reset();
        req = NUM_SRC'(1) << 21;
        step();
        check_owner("wrap_own21", 21);
        req = (NUM_SRC'(1) << 0) | (NUM_SRC'(1) << 22);
        step();
        check_owner("wrap_to22", 22);

        // 6. Release coinciding with tenure expiry
        do_reset();
        req = (NUM_SRC'(1) << 5) | (NUM_SRC'(1) << 6);
        for (int c = 1; c <= 4; c++) begin
            step();
            check_owner("relexp_hold", 5);
        end
        req = NUM_SRC'(1) << 6;
        step();
        check_owner("relexp_new", 6);
        check("relexp_pre", 32'(preempt), 32'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            check_owner("relexp_alone", 6);
            check("relexp_alone_pre", 32'(preempt), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
